instr_mem_loader: RTL and testbench

- Boot-time writer for the word-addressed instruction memory.
- Accepts a byte stream over a valid/ready handshake. Frame: 16-bit word count, then the words, big-endian.
- Assembles 32-bit instructions and issues one write strobe per word at byte address START_ADDR + 4*index (word-aligned, low 2 bits zero).
- Holds the CPU-run indication low until the image is complete.

---
 rtl/instr_mem_loader_if.sv | 20 ++
 rtl/instr_mem_loader.sv | 131 +++++++++++++
 tb/tb_instr_mem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The source of bytes and sink of writes uses master; the loader uses slave.
interface instr_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> one instruction-memory write per 4 bytes, strobe 1 cycle after the 4th byte.
// in_ready is low in IDLE/WRITE/DONE/ERROR (>=5 cycles/word); LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module instr_mem_loader #(
  parameter int          DEPTH      = 12,
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_mem_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CHK;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t      state, state_nxt;
  logic [15:0] count;
  logic [15:0] len_now;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic        fire;
  logic        start_load;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign fire       = bus.in_valid && bus.in_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERROR);
  assign len_now    = {count[15:8], bus.in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN_HI;
      LEN_HI: if (fire) state_nxt = LEN_LO;
      LEN_LO: begin
        if (fire) begin
          if (len_now == 16'd0)              state_nxt = END_ST;
          else if (len_now > 16'(DEPTH))     state_nxt = ERROR;
          else                               state_nxt = DATA;
        end
      end
      DATA: if (fire && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = (words_written + 16'd1 == count) ? END_ST : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK: if (fire) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= 16'h0;
      count         <= 16'h0;
      byte_idx      <= 2'd0;
      shift         <= 24'h0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= 8'h0;
`endif
    end else begin
      bus.in_ready <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) || (state_nxt == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_nxt == CHK)
`endif
                      ;
      busy   <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) || (state_nxt == DATA)
                || (state_nxt == WRITE)
`ifdef LOADER_CHECKSUM_EN
                || (state_nxt == CHK)
`endif
                ;
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERROR);
      bus.mem_we <= (state_nxt == WRITE);

      if (start_load) begin
        words_written <= 16'h0;
        byte_idx      <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        csum          <= 8'h0;
`endif
      end

      if (state == LEN_HI && fire) count[15:8] <= bus.in_data;
      if (state == LEN_LO && fire) count[7:0]  <= bus.in_data;

      if (state == DATA && fire) begin
        shift    <= {shift[15:0], bus.in_data};
        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.in_data;
`endif
        if (byte_idx == 2'd3) begin
          bus.mem_wdata <= {shift, bus.in_data};
          bus.mem_addr  <= START_ADDR + {14'd0, words_written, 2'b00};
        end
      end

      if (state == WRITE) words_written <= words_written + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised and directed bench for instr_mem_loader against a frame-level reference model.
// Works with and without LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;
  localparam int          DEPTH      = 12;
  localparam logic [31:0] START_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [15:0] words_written;

  instr_mem_loader_if bus();

  instr_mem_loader #(.DEPTH(DEPTH), .START_ADDR(START_ADDR)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  frame[$];
  logic [63:0] exp_w[$];
  logic [63:0] got_w[$];
  logic        exp_done, exp_err;
  int          exp_ww;
  int          last_wait;
`ifdef LOADER_CHECKSUM_EN
  bit          bad_ck = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe cycle is recorded; a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      got_w.push_back({bus.mem_addr, bus.mem_wdata});
      check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
    end
  end

  // Reference: what a frame must produce, straight from the frame format.
  task automatic model();
    int         cnt;
    logic [7:0] x;
    logic [31:0] w;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_ww   = 0;
    cnt = int'({frame[0], frame[1]});
    if (cnt > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      w = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_w.push_back({START_ADDR + 32'(4*i), w});
    end
    exp_ww = cnt;
`ifdef LOADER_CHECKSUM_EN
    exp_err  = (frame[2+4*cnt] != x);
    exp_done = !exp_err;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic add_ck();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    if (int'({frame[0], frame[1]}) <= DEPTH) begin
      for (int i = 2; i < frame.size(); i++) x = x ^ frame[i];
      frame.push_back(bad_ck ? (x ^ 8'h01) : x);
    end
`endif
  endtask

  task automatic rand_frame(input int cnt);
    frame.delete();
    frame.push_back(8'(cnt >> 8));
    frame.push_back(8'(cnt));
    if (cnt <= DEPTH)
      for (int i = 0; i < 4*cnt; i++) frame.push_back(8'($urandom));
    add_ck();
  endtask

  task automatic three_word_frame();
    frame = '{8'h00, 8'h03, 8'h80, 8'h01, 8'h06, 8'h0A, 8'h04, 8'h00, 8'h88, 8'h00,
              8'h0C, 8'h01, 8'h18, 8'h00};
    add_ck();
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(n < 200), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    check({tag, "_finish"}, 64'(n < 400), 64'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_nwr"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), got_w[i], exp_w[i]);
    check({tag, "_done"},  64'(done),          64'(exp_done));
    check({tag, "_error"}, 64'(error),         64'(exp_err));
    check({tag, "_words"}, 64'(words_written), 64'(exp_ww));
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_ready"}, 64'(bus.in_ready),  64'd0);
  endtask

  task automatic run_load(input string tag, input int max_gap, input int mid_start);
    got_w.delete();
    model();
    pulse_start();
    foreach (frame[i]) begin
      if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
      if (i == mid_start) pulse_start();
      send_byte(frame[i]);
    end
    wait_end(tag);
    compare(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.in_ready),  64'd0);
    check({tag, "_we"},    64'(bus.mem_we),    64'd0);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_error"}, 64'(error),         64'd0);
    check({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_words"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle");

    three_word_frame();
    run_load("three", 0, -1);

    three_word_frame();
    run_load("gaps", 3, -1);

    frame = '{8'h00, 8'h00};
    add_ck();
    run_load("zero", 0, -1);

    rand_frame(12);
    run_load("full12", 0, -1);
    if (got_w.size() == 12) check("full12_last_addr", {32'h0, got_w[11][63:32]}, 64'h2C);

    frame = '{8'h00, 8'h0D};
    run_load("over13", 0, -1);
    check("over13_err_latency", 64'(last_wait), 64'd0);

    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_ck();
    run_load("after_err", 0, -1);
    if (got_w.size() == 1) check("after_err_addr", {32'h0, got_w[0][63:32]}, 64'h0);

    three_word_frame();
    run_load("mid_start", 1, 4);

    // Asynchronous reset part-way through the first word.
    three_word_frame();
    got_w.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i]);
    #3 rst = 1'b1;
    #1 check_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_idle");
    check("rst_no_write", 64'(got_w.size()), 64'd0);
    run_load("after_rst", 0, -1);

    for (int r = 0; r < 16; r++) begin
`ifdef LOADER_CHECKSUM_EN
      bad_ck = ($urandom_range(0, 3) == 0);
`endif
      rand_frame($urandom_range(0, 13));
      run_load($sformatf("rnd%0d", r), $urandom_range(0, 3), -1);
    end

`ifdef LOADER_CHECKSUM_EN
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_load("ck_good", 0, -1);
    check("ck_good_done", 64'(done), 64'd1);
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_load("ck_bad", 0, -1);
    check("ck_bad_error", 64'(error), 64'd1);
    if (got_w.size() == 1) check("ck_bad_write", got_w[0], 64'h00000000_11223344);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
